// File: rtl/sierpinski_step_ctrl_if.sv
// Command port of the Sierpinski row-generator sequencer: op/seed/divider with a valid/ready handshake.
interface sierpinski_step_ctrl_if #(
   parameter int WIDTH = 14,
   parameter int DIV_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_seed;
   logic [DIV_W-1:0] div;

   modport master (output cmd_valid, output cmd_op, output cmd_seed, output div, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_seed, input div, output cmd_ready);
endinterface

// File: rtl/sierpinski_step_ctrl.sv
// Sequencer for the 14-bit Sierpinski/LFSR row generator: seeds it, paces its steps with a
// programmable divider and counts rows per frame.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for START (free-run) or STEP (single row)
//   S_LOAD  | one-cycle gen_load of the latched seed, divider count cleared
//   S_RUN   | free-running, one gen_step every div_q+1 enabled cycles
//   S_STEP1 | one-cycle single gen_step, then back to idle
module sierpinski_step_ctrl #(
   parameter int WIDTH = 14,
   parameter int DIV_W = 8,
   parameter int ROWS  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   sierpinski_step_ctrl_if.slave   cmd,
   output logic                    gen_load,
   output logic [WIDTH-1:0]        gen_seed,
   output logic                    gen_step,
   output logic [$clog2(ROWS)-1:0] row_idx,
   output logic                    frame_done,
   output logic                    busy
);

   localparam int              RW       = $clog2(ROWS);
   localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
   localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [1:0]      OP_START = 2'b01;
   localparam logic [1:0]      OP_STOP  = 2'b10;
   localparam logic [1:0]      OP_STEP  = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_STEP1} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [RW-1:0]    row_q, row_d;
   logic [RW-1:0]    row_inc;
   logic [WIDTH-1:0] start_seed;
   logic             ready;
   logic             accept;
   logic             load_due;
   logic             step_due;

   // A zero seed would lock the LFSR, so it is promoted to 1.
   assign start_seed = (cmd.cmd_seed == '0) ? SEED_ONE : cmd.cmd_seed;
   assign row_inc    = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         seed_q  <= SEED_ONE;
         row_q   <= '0;
      end else if (ena) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         seed_q  <= seed_d;
         row_q   <= row_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      seed_d   = seed_q;
      row_d    = row_q;
      load_due = 1'b0;
      step_due = 1'b0;
      ready    = ena && (state_q == S_IDLE || state_q == S_RUN);
      accept   = ready && cmd.cmd_valid;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cmd.cmd_op == OP_START) begin
                  state_d = S_LOAD;
                  seed_d  = start_seed;
                  div_d   = cmd.div;
                  row_d   = '0;
               end else if (cmd.cmd_op == OP_STEP) begin
                  state_d = S_STEP1;
               end
            end
         end
         S_LOAD: begin
            load_due = 1'b1;
            cnt_d    = '0;
            state_d  = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == div_q) begin
               step_due = 1'b1;
               cnt_d    = '0;
               row_d    = row_inc;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
            // A step due this cycle is still issued; a restart then rewinds the frame.
            if (accept) begin
               if (cmd.cmd_op == OP_STOP) begin
                  state_d = S_IDLE;
               end else if (cmd.cmd_op == OP_START) begin
                  state_d = S_LOAD;
                  seed_d  = start_seed;
                  div_d   = cmd.div;
                  row_d   = '0;
               end
            end
         end
         S_STEP1: begin
            step_due = 1'b1;
            row_d    = row_inc;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd.cmd_ready = ready;
   assign gen_load      = ena && load_due;
   assign gen_step      = ena && step_due;
   assign frame_done    = gen_step && (row_q == ROW_LAST);
   assign gen_seed      = seed_q;
   assign row_idx       = row_q;
   assign busy          = (state_q != S_IDLE);

endmodule
